// File: rtl/frame_downloader_if.sv
// Memory-side and pixel-queue-side signals of the frame downloader, bundled
// so that the downloader and its environment connect through one port.
interface frame_downloader_if;
    // Memory arbiter / memory read port
    logic        read_rq;
    logic        read_ack;
    logic [20:0] read_addr;
    logic        mem_rd_en;
    logic [31:0] mem_data;
    logic        mem_data_valid;
    // Downstream pixel FIFO
    logic        queue_full;
    logic [16:0] queue_data;
    logic        wr_en;

    // Downloader side
    modport master (
        output read_rq, read_addr, mem_rd_en, queue_data, wr_en,
        input  read_ack, mem_data, mem_data_valid, queue_full
    );

    // Memory / FIFO side
    modport slave (
        input  read_rq, read_addr, mem_rd_en, queue_data, wr_en,
        output read_ack, mem_data, mem_data_valid, queue_full
    );
endinterface

// File: rtl/frame_downloader.sv
// Reads one frame of RGB565 pixels from memory in fixed-size bursts and pushes
// them, preceded by a frame-start marker, into a downstream pixel FIFO.
// MEMORY_BURST is expected to be a power of two of at least 8 bytes.
module frame_downloader #(
    parameter int MEMORY_BURST = 32,
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int TCMD         = 19
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [20:0]         base_addr,
    output logic                download_done,
    frame_downloader_if.master  bus
);
    localparam int PB           = MEMORY_BURST / 2;
    localparam int BW           = MEMORY_BURST / 4;
    localparam int FRAME_PIXELS = FRAME_WIDTH * FRAME_HEIGHT;
    localparam int CW           = $clog2(FRAME_PIXELS + PB + 1);
    localparam int PIW          = $clog2(PB);
    localparam int WIW          = $clog2(BW);
    localparam int CTW          = $clog2(TCMD + 2);

    typedef enum logic [8:0] {
        IDLE    = 9'b0_0000_0001,
        SOF     = 9'b0_0000_0010,
        REQ     = 9'b0_0000_0100,
        CMD     = 9'b0_0000_1000,
        CAPTURE = 9'b0_0001_0000,
        HOLD    = 9'b0_0010_0000,
        PUSH    = 9'b0_0100_0000,
        NEXT    = 9'b0_1000_0000,
        DONE    = 9'b1_0000_0000
    } state_t;

    state_t          state, state_next;
    logic [20:0]     addr_cnt;
    logic [CW-1:0]   pix_cnt;
    logic [WIW-1:0]  word_idx;
    logic [PIW-1:0]  pix_idx;
    logic [CTW-1:0]  cyc_cnt;
    logic [31:0]     burst_buf [BW];

    logic [CW-1:0]   remaining;
    logic [CW-1:0]   burst_len;
    logic [CW-1:0]   pix_sum;
    logic [31:0]     cur_word;
    logic [15:0]     cur_pixel;

    // Burst length is clipped so the last burst of a frame stops exactly at the frame end.
    always_comb begin
        remaining = CW'(FRAME_PIXELS) - pix_cnt;
        burst_len = (remaining < CW'(PB)) ? remaining : CW'(PB);
        pix_sum   = pix_cnt + burst_len;
        cur_word  = burst_buf[pix_idx[PIW-1:1]];
        cur_pixel = pix_idx[0] ? cur_word[31:16] : cur_word[15:0];
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state and output decode.
    always_comb begin
        // NOTE: every output and the next state get a default first, so no
        // path through the case can leave a value unassigned and infer a latch.
        state_next        = state;
        bus.read_rq       = 1'b0;
        bus.mem_rd_en     = 1'b0;
        bus.wr_en         = 1'b0;
        bus.queue_data    = 17'h0;
        download_done     = 1'b0;
        unique case (state)
            IDLE: if (start) state_next = SOF;
            SOF: begin
                if (!bus.queue_full) begin
                    bus.wr_en      = 1'b1;
                    bus.queue_data = 17'h10000;
                    state_next     = REQ;
                end
            end
            REQ: begin
                bus.read_rq = 1'b1;
                if (bus.read_ack) state_next = CMD;
            end
            CMD: begin
                bus.read_rq   = 1'b1;
                bus.mem_rd_en = 1'b1;
                state_next    = CAPTURE;
            end
            CAPTURE: begin
                bus.read_rq = 1'b1;
                if (bus.mem_data_valid && word_idx == WIW'(BW - 1)) state_next = HOLD;
            end
            HOLD: begin
                bus.read_rq = 1'b1;
                if (cyc_cnt >= CTW'(TCMD)) state_next = PUSH;
            end
            PUSH: begin
                if (!bus.queue_full) begin
                    bus.wr_en      = 1'b1;
                    bus.queue_data = {1'b0, cur_pixel};
                    if (CW'(pix_idx) == burst_len - CW'(1)) state_next = NEXT;
                end
            end
            NEXT: state_next = (pix_sum == CW'(FRAME_PIXELS)) ? DONE : REQ;
            DONE: begin
                download_done = 1'b1;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Read address is the running frame address; it only moves on start and between bursts.
    assign bus.read_addr = addr_cnt;

    // Address, pixel, word, push-index and command-cycle counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_cnt <= '0;
            pix_cnt  <= '0;
            word_idx <= '0;
            pix_idx  <= '0;
            cyc_cnt  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        addr_cnt <= base_addr;
                        pix_cnt  <= '0;
                    end
                end
                CMD: begin
                    cyc_cnt  <= '0;
                    word_idx <= '0;
                    pix_idx  <= '0;
                end
                CAPTURE: begin
                    if (bus.mem_data_valid) word_idx <= word_idx + 1'b1;
                    if (cyc_cnt < CTW'(TCMD)) cyc_cnt <= cyc_cnt + 1'b1;
                end
                HOLD: if (cyc_cnt < CTW'(TCMD)) cyc_cnt <= cyc_cnt + 1'b1;
                PUSH: if (!bus.queue_full) pix_idx <= pix_idx + 1'b1;
                NEXT: begin
                    pix_cnt  <= pix_sum;
                    addr_cnt <= addr_cnt + 21'(burst_len);
                end
                default: ;
            endcase
        end
    end

    // Burst buffer fills only while capturing; an abandoned burst leaves stale words that are never read.
    always_ff @(posedge clk) begin
        // NOTE: the buffer is deliberately not reset; every slot is rewritten
        // before it is read, so a reset would only add fan-out.
        if (state == CAPTURE && bus.mem_data_valid) burst_buf[word_idx] <= bus.mem_data;
    end
endmodule

// File: tb/tb_frame_downloader.sv
// Directed bench: two downloader instances (4x8 and 5x4 frames) share one
// memory responder and one pixel monitor, selected by sel.
`timescale 1ns/1ps
module tb_frame_downloader;
    localparam int TCMD = 19;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [20:0] base_addr = '0;
    logic        read_ack = 1'b0;
    logic        mem_data_valid = 1'b0;
    logic [31:0] mem_data = '0;
    logic        queue_full = 1'b0;
    logic        sel = 1'b0;
    int          data_delay = 1;
    logic        done_a, done_b;

    int tests = 0;
    int fails = 0;

    frame_downloader_if bus_a();
    frame_downloader_if bus_b();

    assign bus_a.read_ack       = read_ack;
    assign bus_a.mem_data       = mem_data;
    assign bus_a.mem_data_valid = mem_data_valid;
    assign bus_a.queue_full     = queue_full;
    assign bus_b.read_ack       = read_ack;
    assign bus_b.mem_data       = mem_data;
    assign bus_b.mem_data_valid = mem_data_valid;
    assign bus_b.queue_full     = queue_full;

    frame_downloader #(.FRAME_WIDTH(4), .FRAME_HEIGHT(8)) u_dut_a (
        .clk           (clk),
        .reset         (reset),
        .start         (start & ~sel),
        .base_addr     (base_addr),
        .download_done (done_a),
        .bus           (bus_a)
    );

    frame_downloader #(.FRAME_WIDTH(5), .FRAME_HEIGHT(4)) u_dut_b (
        .clk           (clk),
        .reset         (reset),
        .start         (start & sel),
        .base_addr     (base_addr),
        .download_done (done_b),
        .bus           (bus_b)
    );

    // Outputs of the selected instance
    logic        m_rq, m_rd_en, m_wr, m_done;
    logic [16:0] m_qd;
    logic [20:0] m_raddr;
    assign m_rq    = sel ? bus_b.read_rq    : bus_a.read_rq;
    assign m_rd_en = sel ? bus_b.mem_rd_en  : bus_a.mem_rd_en;
    assign m_wr    = sel ? bus_b.wr_en      : bus_a.wr_en;
    assign m_done  = sel ? done_b           : done_a;
    assign m_qd    = sel ? bus_b.queue_data : bus_a.queue_data;
    assign m_raddr = sel ? bus_b.read_addr  : bus_a.read_addr;

    always #5 clk = ~clk;

    // Pixel value stored at a given pixel address in the memory model
    function automatic logic [15:0] pix(input logic [20:0] a);
        return a[15:0] ^ {a[20:16], 11'h000};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Monitor logs
    logic [16:0] pushed[$];
    logic [20:0] rd_addrs[$];
    int          holds[$];
    int          words_at_drop[$];
    int          done_cnt = 0;
    int          wr_viol = 0;
    int          words_sent = 0;

    // Monitor: samples the selected instance 2 ns after each falling edge.
    initial begin
        int  hold_cnt;
        bit  in_burst;
        hold_cnt = 0;
        in_burst = 0;
        forever begin
            @(negedge clk);
            #2;
            if (m_wr) begin
                if (queue_full) wr_viol++;
                pushed.push_back(m_qd);
            end
            if (m_rd_en) begin
                rd_addrs.push_back(m_raddr);
                hold_cnt = 0;
                in_burst = 1;
            end else if (in_burst) begin
                if (m_rq) hold_cnt++;
                else begin
                    in_burst = 0;
                    holds.push_back(hold_cnt);
                    words_at_drop.push_back(words_sent);
                end
            end
            if (m_done) done_cnt++;
        end
    end

    // Memory responder: grant 2 cycles after request, BW=8 words after data_delay, plus one stray word.
    initial begin
        logic [20:0] ra;
        forever begin
            @(negedge clk);
            if (m_rq) begin
                repeat (2) @(negedge clk);
                read_ack   = 1'b1;
                words_sent = 0;
                @(negedge clk);
                read_ack = 1'b0;
                ra       = m_raddr;
                repeat (data_delay) @(negedge clk);
                for (int k = 0; k < 8; k++) begin
                    mem_data_valid = 1'b1;
                    mem_data       = {pix(ra + 21'(2 * k + 1)), pix(ra + 21'(2 * k))};
                    words_sent     = k + 1;
                    @(negedge clk);
                end
                mem_data = 32'hDEADBEEF;
                @(negedge clk);
                mem_data_valid = 1'b0;
                mem_data       = '0;
                while (m_rq) @(negedge clk);
            end
        end
    end

    task automatic clear_logs();
        pushed.delete();
        rd_addrs.delete();
        holds.delete();
        words_at_drop.delete();
        done_cnt = 0;
        wr_viol  = 0;
    endtask

    task automatic run_frame(input logic [20:0] base, input int delay, input bit toggle, input bit sip);
        bit pulsed;
        int cyc;
        pulsed = 0;
        cyc    = 0;
        clear_logs();
        data_delay = delay;
        @(negedge clk);
        base_addr = base;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        base_addr = '0;
        while (done_cnt == 0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (toggle) queue_full = ~queue_full;
            if (sip && !pulsed && pushed.size() == 5) begin
                start  = 1'b1;
                pulsed = 1;
            end else begin
                start = 1'b0;
            end
        end
        start      = 1'b0;
        queue_full = 1'b0;
        check("frame_finished_in_budget", 32'(cyc < 3000), 32'd1);
        repeat (30) @(negedge clk);
    endtask

    task automatic verify_frame(input string name, input logic [20:0] base, input int npix,
                                input logic [20:0] second_addr);
        check({name, "_push_count"}, 32'(pushed.size()), 32'(npix + 1));
        if (pushed.size() > 0) check({name, "_marker"}, 32'(pushed[0]), 32'h10000);
        for (int i = 1; i < pushed.size() && i <= npix; i++)
            check($sformatf("%s_pix%0d", name, i - 1), 32'(pushed[i]),
                  {15'h0, 1'b0, pix(base + 21'(i - 1))});
        check({name, "_burst_count"}, 32'(rd_addrs.size()), 32'd2);
        if (rd_addrs.size() > 0) check({name, "_read_addr0"}, 32'(rd_addrs[0]), 32'(base));
        if (rd_addrs.size() > 1) check({name, "_read_addr1"}, 32'(rd_addrs[1]), 32'(second_addr));
        check({name, "_done_pulses"}, 32'(done_cnt), 32'd1);
        check({name, "_wr_while_full"}, 32'(wr_viol), 32'd0);
        for (int i = 0; i < holds.size(); i++) begin
            check($sformatf("%s_rq_hold_ge_tcmd%0d", name, i), 32'(holds[i] >= TCMD), 32'd1);
            check($sformatf("%s_words_before_release%0d", name, i), 32'(words_at_drop[i]), 32'd8);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_read_rq"},       32'(m_rq),    32'd0);
        check({name, "_mem_rd_en"},     32'(m_rd_en), 32'd0);
        check({name, "_wr_en"},         32'(m_wr),    32'd0);
        check({name, "_download_done"}, 32'(m_done),  32'd0);
        check({name, "_queue_data"},    32'(m_qd),    32'd0);
        check({name, "_read_addr"},     32'(m_raddr), 32'd0);
    endtask

    initial begin
        int cyc;

        // Reset state of both instances
        #12;
        sel = 1'b0; #1; check_outputs_zero("reset_a");
        sel = 1'b1; #1; check_outputs_zero("reset_b");
        sel = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #2; check_outputs_zero("idle_after_reset_a");

        // Basic 32-pixel frame, two bursts
        run_frame(21'h000100, 1, 1'b0, 1'b0);
        verify_frame("basic", 21'h000100, 32, 21'h000110);

        // Back-pressure toggling every cycle
        run_frame(21'h000040, 1, 1'b1, 1'b0);
        verify_frame("backpressure", 21'h000040, 32, 21'h000050);

        // Address wrap at the top of the 21-bit space
        run_frame(21'h1FFFF8, 1, 1'b0, 1'b0);
        verify_frame("wrap", 21'h1FFFF8, 32, 21'h000008);

        // Late data and a stray start during PUSH
        run_frame(21'h000180, 10, 1'b0, 1'b1);
        verify_frame("late_data", 21'h000180, 32, 21'h000190);

        // Reset in the middle of a capture
        clear_logs();
        data_delay = 1;
        @(negedge clk);
        base_addr = 21'h000200;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        base_addr = '0;
        cyc = 0;
        while (rd_addrs.size() == 0 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check("reset_test_reached_capture", 32'(cyc < 500), 32'd1);
        repeat (3) @(negedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_outputs_zero("async_reset");
        @(negedge clk);
        check_outputs_zero("held_reset");
        reset = 1'b0;
        repeat (25) @(negedge clk);
        check("post_reset_no_push", 32'(pushed.size()), 32'd1);
        check("post_reset_no_read", 32'(rd_addrs.size()), 32'd1);
        check("post_reset_no_done", 32'(done_cnt), 32'd0);
        #2; check_outputs_zero("post_reset_quiet");
        run_frame(21'h000300, 1, 1'b0, 1'b0);
        verify_frame("after_reset", 21'h000300, 32, 21'h000310);

        // 20-pixel frame: second burst is short
        sel = 1'b1;
        repeat (2) @(negedge clk);
        run_frame(21'h000020, 15, 1'b0, 1'b0);
        verify_frame("short_last_burst", 21'h000020, 20, 21'h000030);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/frame_downloader.md
FRAME_DOWNLOADER -- requirements
Module: frame_downloader

Interface
REQ-001 Parameter MEMORY_BURST, default 32: bytes per memory burst; pixels per burst PB = MEMORY_BURST/2; 32-bit words per burst BW = MEMORY_BURST/4.
REQ-002 Parameter FRAME_WIDTH, default 640: pixels per line.
REQ-003 Parameter FRAME_HEIGHT, default 480: lines per frame; FRAME_PIXELS = FRAME_WIDTH*FRAME_HEIGHT.
REQ-004 Parameter TCMD, default 19: minimum cycles read_rq stays asserted after the mem_rd_en pulse.
REQ-005 clk  input  1  single clock; all logic rising-edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  one-cycle pulse, begin frame readout; sampled only in IDLE.
REQ-008 base_addr  input  21  frame base address in pixel units; sampled on accepted start.
REQ-009 read_rq  output  1  memory arbiter request, held for whole burst transaction.
REQ-010 read_ack  input  1  arbiter grant for read_rq.
REQ-011 read_addr  output  21  burst start address.
REQ-012 mem_rd_en  output  1  one-cycle read command strobe.
REQ-013 mem_data  input  32  read word; bits [15:0] = lower-address pixel.
REQ-014 mem_data_valid  input  1  mem_data valid this cycle.
REQ-015 queue_full  input  1  downstream pixel FIFO full.
REQ-016 queue_data  output  17  bit16 = control marker, [15:0] = RGB565 pixel.
REQ-017 wr_en  output  1  push queue_data into FIFO this cycle.
REQ-018 download_done  output  1  one-cycle pulse at frame completion.

Function
REQ-019 States: IDLE, SOF, REQ, CMD, CAPTURE, HOLD, PUSH, NEXT, DONE; one-hot encoding.
REQ-020 IDLE: start=1 -> latch base_addr into address counter, clear pixel counter, go SOF; start in any other state is ignored.
REQ-021 SOF: when queue_full=0 -> wr_en=1, queue_data=17'h10000 (frame-start marker), go REQ; hold while full.
REQ-022 REQ: read_rq=1; read_ack=1 -> go CMD.
REQ-023 CMD: mem_rd_en=1 for exactly one cycle, read_addr = address counter, cycle counter cleared, go CAPTURE.
REQ-024 CAPTURE: each cycle mem_data_valid=1 stores mem_data into burst buffer slot word_idx (0..BW-1), word_idx+1; after BW words go HOLD; mem_data_valid beyond BW words ignored.
REQ-025 Cycle counter increments every cycle from CMD exit; HOLD exits to PUSH when counter >= TCMD; read_rq=1 in REQ, CMD, CAPTURE, HOLD, else 0.
REQ-026 PUSH: emits burst pixels in address order (word0[15:0], word0[31:16], word1[15:0] ...); one pixel per cycle with queue_full=0, wr_en=1, queue_data={1'b0,pixel}; queue_full=1 -> wr_en=0, index held.
REQ-027 Burst length L = min(PB, FRAME_PIXELS - pixel counter); PUSH ends after L pixels, go NEXT; excess buffered pixels discarded.
REQ-028 NEXT: pixel counter += L, address counter += L (21-bit, wraps modulo 2^21); pixel counter == FRAME_PIXELS -> DONE, else REQ.
REQ-029 DONE: download_done=1 for one cycle, go IDLE.
REQ-030 wr_en never asserted in a cycle with queue_full=1; exactly FRAME_PIXELS+1 pushes per frame.
REQ-031 Pixel counter width >= ceil(log2(FRAME_PIXELS+1)); comparison exact equality.

Reset
REQ-032 reset=1 at any time, including mid-burst, forces IDLE within the same cycle: read_rq, mem_rd_en, wr_en, download_done = 0; queue_data, read_addr, counters, word_idx = 0.
REQ-033 After reset deassertion no output changes until next start; an in-flight memory burst is abandoned, its data ignored.

Verification
REQ-034 FRAME_WIDTH=4, FRAME_HEIGHT=8, base_addr=0x100, ack 2 cycles after read_rq, 8 valid words each burst -> marker 0x10000 then 32 pixels in address order; mem_rd_en at read_addr 0x100 then 0x110; one download_done.
REQ-035 queue_full toggled every other cycle during PUSH -> no wr_en while full, no pixel lost or duplicated, order preserved.
REQ-036 FRAME_WIDTH=5, FRAME_HEIGHT=4 (20 pixels) -> bursts at base, base+16; second burst pushes only 4 pixels; done after 21 pushes.
REQ-037 base_addr=0x1FFFF8, 32-pixel frame -> second read_addr = 0x000008 (wrap).
REQ-038 reset pulsed during CAPTURE -> all outputs 0 next edge; new start afterwards produces full clean frame starting with marker.
REQ-039 start pulsed during PUSH -> ignored; mem_data_valid delayed 10 cycles after mem_rd_en -> read_rq held until all BW words captured and >= TCMD cycles elapsed.
